// File: rtl/sram_bridge_pkg.sv
// -----------------------------------------------------------------------------
// sram_bridge_pkg
// Shared types and helpers for the CPU-to-SRAM request bridge:
//   - state_t     : bridge FSM states
//   - req_t       : latched CPU request payload (we / be / wdata)
//   - BE_FULL     : byte-enable pattern for a full-word store
//   - merge_bytes : byte-lane merge used by read-modify-write stores
// -----------------------------------------------------------------------------
package sram_bridge_pkg;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned BE_W   = DATA_W / 8;

    localparam logic [BE_W-1:0] BE_FULL = 4'hF;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        RD     = 3'd1,
        MERGE  = 3'd2,
        WR     = 3'd3,
        WDRAIN = 3'd4,
        ACK    = 3'd5
    } state_t;

    typedef struct packed {
        logic              we;
        logic [BE_W-1:0]   be;
        logic [DATA_W-1:0] wdata;
    } req_t;

    // Replace each byte lane of old_word whose enable is set with new_word's lane.
    function automatic logic [DATA_W-1:0] merge_bytes(
        input logic [DATA_W-1:0] old_word,
        input logic [DATA_W-1:0] new_word,
        input logic [BE_W-1:0]   be
    );
        logic [DATA_W-1:0] res;
        res = old_word;
        for (int i = 0; i < int'(BE_W); i++) begin
            if (be[i]) begin
                res[8*i +: 8] = new_word[8*i +: 8];
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/sram_watchdog.sv
// -----------------------------------------------------------------------------
// sram_watchdog
// Cycle counter that flags when a memory stage has been waited on for
// TIMEOUT cycles. Used only when SRAM_BRIDGE_TIMEOUT_EN is defined.
//   clk, rst  : clock, synchronous active-high reset
//   clear     : restart the count at zero (has priority over enable)
//   enable    : count this cycle
//   expire_c  : combinational, high in the TIMEOUT-th enabled cycle
// -----------------------------------------------------------------------------
module sram_watchdog #(
    parameter int unsigned TIMEOUT = 15
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expire_c
);

    localparam int unsigned CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    logic [CNT_W-1:0] count;

    // Count holds 0..TIMEOUT-1; expiry fires on the last value.
    assign expire_c = enable && (count == CNT_W'(TIMEOUT - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable && !expire_c) begin
            count <= count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/sram_req_bridge.sv
// -----------------------------------------------------------------------------
// sram_req_bridge
// Bridges the CPU data-memory port onto the SRAM read and write stages. One
// access at a time; the CPU is stalled until the access is acknowledged.
// Partial-word stores are done as read / merge / full-word write.
//
// Build option: define SRAM_BRIDGE_TIMEOUT_EN to add a watchdog that abandons
// a read or write after TIMEOUT cycles and reports cpu_err with cpu_ack.
// Without it the bridge waits indefinitely and cpu_err stays 0.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   cpu_req/we/be/addr/wdata CPU request (held stable until cpu_ack)
//   cpu_rdata, cpu_ack       load data and one-cycle completion pulse
//   cpu_err                  timeout flag, valid with cpu_ack
//   cpu_stall                combinational CPU pipeline hold
//   rd_ce, rd_addr           read-stage request and word address
//   rd_data, rd_fin          read-stage data and done
//   wr_ce, wr_addr, wr_data  write-stage request, word address, data
//   wr_fin                   write-stage done
// -----------------------------------------------------------------------------
module sram_req_bridge
    import sram_bridge_pkg::*;
#(
    parameter int unsigned ADDR_W  = 20,
    parameter int unsigned TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [BE_W-1:0]   cpu_be,
    input  logic [31:0]       cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_ack,
    output logic              cpu_err,
    output logic              cpu_stall,

    output logic              rd_ce,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [DATA_W-1:0] rd_data,
    input  logic              rd_fin,

    output logic              wr_ce,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [DATA_W-1:0] wr_data,
    input  logic              wr_fin
);

    state_t state;
    state_t state_next;

    req_t              req_q;
    logic [DATA_W-1:0] buf_q;

    req_t              req_d;
    logic [DATA_W-1:0] buf_d;
    logic [DATA_W-1:0] cpu_rdata_d;
    logic              cpu_ack_d;
    logic              cpu_err_d;
    logic              rd_ce_d;
    logic [ADDR_W-1:0] rd_addr_d;
    logic              wr_ce_d;
    logic [ADDR_W-1:0] wr_addr_d;
    logic [DATA_W-1:0] wr_data_d;

    logic [ADDR_W-1:0] word_addr;
    logic              timeout_c;

    assign word_addr = cpu_addr[ADDR_W+1:2];

    // Watchdog: restarts on every state change, counts only while waiting on a stage.
`ifdef SRAM_BRIDGE_TIMEOUT_EN
    logic wd_clear;
    logic wd_enable;

    assign wd_clear  = (state_next != state);
    assign wd_enable = (state == RD) || (state == WR);

    sram_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_watchdog (
        .clk      (clk),
        .rst      (rst),
        .clear    (wd_clear),
        .enable   (wd_enable),
        .expire_c (timeout_c)
    );
`else
    assign timeout_c = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic; a fin always beats a same-cycle timeout.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (cpu_req) begin
                    if (!cpu_we) begin
                        state_next = RD;
                    end else if (cpu_be == BE_FULL) begin
                        state_next = WR;
                    end else if (cpu_be == '0) begin
                        state_next = ACK;
                    end else begin
                        state_next = RD;
                    end
                end
            end
            RD: begin
                if (rd_fin) begin
                    state_next = req_q.we ? MERGE : ACK;
                end else if (timeout_c) begin
                    state_next = ACK;
                end
            end
            MERGE: begin
                state_next = WR;
            end
            WR: begin
                if (wr_fin) begin
                    state_next = WDRAIN;
                end else if (timeout_c) begin
                    state_next = ACK;
                end
            end
            // Write stage is back in idle once it drops wfin.
            WDRAIN: begin
                if (!wr_fin) begin
                    state_next = ACK;
                end
            end
            ACK: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Output / datapath next values; strobes follow the state being entered.
    always_comb begin
        req_d       = req_q;
        buf_d       = buf_q;
        cpu_rdata_d = cpu_rdata;
        rd_addr_d   = rd_addr;
        wr_addr_d   = wr_addr;
        wr_data_d   = wr_data;
        cpu_err_d   = 1'b0;
        rd_ce_d     = (state_next == RD);
        wr_ce_d     = (state_next == WR);
        cpu_ack_d   = (state_next == ACK);

        case (state)
            IDLE: begin
                if (cpu_req) begin
                    req_d.we    = cpu_we;
                    req_d.be    = cpu_be;
                    req_d.wdata = cpu_wdata;
                    if (state_next == RD) begin
                        rd_addr_d = word_addr;
                    end
                    if (state_next == WR) begin
                        wr_addr_d = word_addr;
                        wr_data_d = cpu_wdata;
                    end
                end
            end
            RD: begin
                if (rd_fin) begin
                    buf_d = rd_data;
                    if (!req_q.we) begin
                        cpu_rdata_d = rd_data;
                    end
                end else if (timeout_c) begin
                    cpu_err_d = 1'b1;
                end
            end
            MERGE: begin
                buf_d     = merge_bytes(buf_q, req_q.wdata, req_q.be);
                wr_data_d = buf_d;
                wr_addr_d = rd_addr;
            end
            WR: begin
                if (!wr_fin && timeout_c) begin
                    cpu_err_d = 1'b1;
                end
            end
            default: begin
            end
        endcase
    end

    // Registered outputs and request/data buffers.
    always_ff @(posedge clk) begin
        if (rst) begin
            req_q     <= '0;
            buf_q     <= '0;
            cpu_rdata <= '0;
            cpu_ack   <= 1'b0;
            cpu_err   <= 1'b0;
            rd_ce     <= 1'b0;
            rd_addr   <= '0;
            wr_ce     <= 1'b0;
            wr_addr   <= '0;
            wr_data   <= '0;
        end else begin
            req_q     <= req_d;
            buf_q     <= buf_d;
            cpu_rdata <= cpu_rdata_d;
            cpu_ack   <= cpu_ack_d;
            cpu_err   <= cpu_err_d;
            rd_ce     <= rd_ce_d;
            rd_addr   <= rd_addr_d;
            wr_ce     <= wr_ce_d;
            wr_addr   <= wr_addr_d;
            wr_data   <= wr_data_d;
        end
    end

    // Stall mirrors the request while idle so a new access holds the pipe at once.
    always_comb begin
        cpu_stall = 1'b0;
        if (!rst) begin
            case (state)
                IDLE:    cpu_stall = cpu_req;
                ACK:     cpu_stall = 1'b0;
                default: cpu_stall = 1'b1;
            endcase
        end
    end

    // Byte-offset and upper address bits carry no information for word accesses.
    logic unused_ok;
    assign unused_ok = ^{cpu_addr[1:0], cpu_addr[31:ADDR_W+2], 32'(TIMEOUT)};

endmodule

// File: tb/tb_sram_req_bridge.sv
// -----------------------------------------------------------------------------
// tb_sram_req_bridge
// Directed bench for sram_req_bridge: loads, full stores, byte-merge stores,
// empty stores, long waits (or watchdog timeouts when SRAM_BRIDGE_TIMEOUT_EN
// is defined) and reset in the middle of a write.
// -----------------------------------------------------------------------------
module tb_sram_req_bridge;

    logic        clk;
    logic        rst;
    logic        cpu_req;
    logic        cpu_we;
    logic [3:0]  cpu_be;
    logic [31:0] cpu_addr;
    logic [31:0] cpu_wdata;
    logic [31:0] cpu_rdata;
    logic        cpu_ack;
    logic        cpu_err;
    logic        cpu_stall;
    logic        rd_ce;
    logic [19:0] rd_addr;
    logic [31:0] rd_data;
    logic        rd_fin;
    logic        wr_ce;
    logic [19:0] wr_addr;
    logic [31:0] wr_data;
    logic        wr_fin;

    int total = 0;
    int bad   = 0;

    sram_req_bridge #(
        .ADDR_W  (20),
        .TIMEOUT (15)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .cpu_req   (cpu_req),
        .cpu_we    (cpu_we),
        .cpu_be    (cpu_be),
        .cpu_addr  (cpu_addr),
        .cpu_wdata (cpu_wdata),
        .cpu_rdata (cpu_rdata),
        .cpu_ack   (cpu_ack),
        .cpu_err   (cpu_err),
        .cpu_stall (cpu_stall),
        .rd_ce     (rd_ce),
        .rd_addr   (rd_addr),
        .rd_data   (rd_data),
        .rd_fin    (rd_fin),
        .wr_ce     (wr_ce),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .wr_fin    (wr_fin)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic test_reset();
        rst = 1'b1; cpu_req = 1'b1; cpu_we = 1'b0; cpu_be = 4'hF;
        cpu_addr = 32'h0; cpu_wdata = 32'h0; rd_data = 32'h0; rd_fin = 1'b0; wr_fin = 1'b0;
        repeat (2) @(negedge clk);
        total++; if (cpu_stall !== 1'b0) begin bad++; $display("FAIL reset_stall: got %b want 0", cpu_stall); end
        total++; if ({cpu_ack, cpu_err, rd_ce, wr_ce} !== 4'b0) begin bad++; $display("FAIL reset_strobes: got %b want 0000", {cpu_ack, cpu_err, rd_ce, wr_ce}); end
        total++; if (cpu_rdata !== 32'h0) begin bad++; $display("FAIL reset_rdata: got %h want 0", cpu_rdata); end
        total++; if ({rd_addr, wr_addr, wr_data} !== 72'h0) begin bad++; $display("FAIL reset_addr_data: got %h want 0", {rd_addr, wr_addr, wr_data}); end
        cpu_req = 1'b0; rst = 1'b0;
        @(negedge clk);
        total++; if ({cpu_stall, rd_ce, wr_ce, cpu_ack} !== 4'b0) begin bad++; $display("FAIL reset_idle: got %b want 0000", {cpu_stall, rd_ce, wr_ce, cpu_ack}); end
    endtask

    task automatic test_load();
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_be = 4'hF; cpu_addr = 32'h0000_0010;
        #1;
        total++; if (cpu_stall !== 1'b1) begin bad++; $display("FAIL load_idle_stall: got %b want 1", cpu_stall); end
        @(negedge clk);
        total++; if (rd_ce !== 1'b1) begin bad++; $display("FAIL load_rd_ce: got %b want 1", rd_ce); end
        total++; if (rd_addr !== 20'h4) begin bad++; $display("FAIL load_rd_addr: got %h want 4", rd_addr); end
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            total++; if ({rd_ce, wr_ce, cpu_ack, cpu_stall} !== 4'b1001) begin bad++; $display("FAIL load_wait: got %b want 1001", {rd_ce, wr_ce, cpu_ack, cpu_stall}); end
        end
        rd_fin = 1'b1; rd_data = 32'hDEAD_BEEF;
        @(negedge clk);
        rd_fin = 1'b0; rd_data = 32'h0;
        total++; if ({cpu_ack, cpu_err, rd_ce, wr_ce, cpu_stall} !== 5'b10000) begin bad++; $display("FAIL load_ack: got %b want 10000", {cpu_ack, cpu_err, rd_ce, wr_ce, cpu_stall}); end
        total++; if (cpu_rdata !== 32'hDEAD_BEEF) begin bad++; $display("FAIL load_rdata: got %h want deadbeef", cpu_rdata); end
        cpu_req = 1'b0;
        @(negedge clk);
        total++; if ({cpu_ack, wr_ce} !== 2'b00) begin bad++; $display("FAIL load_ack_pulse: got %b want 00", {cpu_ack, wr_ce}); end
        total++; if (cpu_rdata !== 32'hDEAD_BEEF) begin bad++; $display("FAIL load_rdata_hold: got %h want deadbeef", cpu_rdata); end
    endtask

    task automatic test_full_store();
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_be = 4'hF; cpu_addr = 32'h8; cpu_wdata = 32'h1234_5678;
        @(negedge clk);
        total++; if ({wr_ce, rd_ce} !== 2'b10) begin bad++; $display("FAIL fst_wr_ce: got %b want 10", {wr_ce, rd_ce}); end
        total++; if (wr_addr !== 20'h2) begin bad++; $display("FAIL fst_wr_addr: got %h want 2", wr_addr); end
        total++; if (wr_data !== 32'h1234_5678) begin bad++; $display("FAIL fst_wr_data: got %h want 12345678", wr_data); end
        @(negedge clk);
        total++; if ({wr_ce, wr_addr, wr_data} !== {1'b1, 20'h2, 32'h1234_5678}) begin bad++; $display("FAIL fst_hold: got %h want 1000021234 5678", {wr_ce, wr_addr, wr_data}); end
        wr_fin = 1'b1;
        @(negedge clk);
        total++; if ({wr_ce, cpu_ack, cpu_stall} !== 3'b001) begin bad++; $display("FAIL fst_wr_ce_fall: got %b want 001", {wr_ce, cpu_ack, cpu_stall}); end
        @(negedge clk);
        total++; if ({wr_ce, cpu_ack, cpu_stall} !== 3'b001) begin bad++; $display("FAIL fst_drain: got %b want 001", {wr_ce, cpu_ack, cpu_stall}); end
        wr_fin = 1'b0;
        @(negedge clk);
        total++; if ({cpu_ack, cpu_err, cpu_stall} !== 3'b100) begin bad++; $display("FAIL fst_ack: got %b want 100", {cpu_ack, cpu_err, cpu_stall}); end
        cpu_req = 1'b0;
        @(negedge clk);
        total++; if (cpu_ack !== 1'b0) begin bad++; $display("FAIL fst_ack_pulse: got %b want 0", cpu_ack); end
    endtask

    task automatic test_byte_store();
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_be = 4'b0010; cpu_addr = 32'h20; cpu_wdata = 32'h0000_EE00;
        @(negedge clk);
        total++; if ({rd_ce, wr_ce} !== 2'b10) begin bad++; $display("FAIL bst_rd_ce: got %b want 10", {rd_ce, wr_ce}); end
        total++; if (rd_addr !== 20'h8) begin bad++; $display("FAIL bst_rd_addr: got %h want 8", rd_addr); end
        rd_fin = 1'b1; rd_data = 32'hAABB_CCDD;
        @(negedge clk);
        rd_fin = 1'b0; rd_data = 32'h0;
        total++; if ({rd_ce, wr_ce, cpu_ack, cpu_stall} !== 4'b0001) begin bad++; $display("FAIL bst_merge: got %b want 0001", {rd_ce, wr_ce, cpu_ack, cpu_stall}); end
        @(negedge clk);
        total++; if ({rd_ce, wr_ce} !== 2'b01) begin bad++; $display("FAIL bst_wr_ce: got %b want 01", {rd_ce, wr_ce}); end
        total++; if (wr_data !== 32'hAABB_EEDD) begin bad++; $display("FAIL bst_wr_data: got %h want aabbeedd", wr_data); end
        total++; if (wr_addr !== 20'h8) begin bad++; $display("FAIL bst_wr_addr: got %h want 8", wr_addr); end
        wr_fin = 1'b1;
        @(negedge clk);
        wr_fin = 1'b0;
        total++; if ({wr_ce, cpu_ack} !== 2'b00) begin bad++; $display("FAIL bst_drain: got %b want 00", {wr_ce, cpu_ack}); end
        @(negedge clk);
        total++; if ({cpu_ack, cpu_err} !== 2'b10) begin bad++; $display("FAIL bst_ack: got %b want 10", {cpu_ack, cpu_err}); end
        total++; if (cpu_rdata !== 32'hDEAD_BEEF) begin bad++; $display("FAIL bst_rdata_kept: got %h want deadbeef", cpu_rdata); end
        cpu_req = 1'b0;
        @(negedge clk);
        total++; if (cpu_ack !== 1'b0) begin bad++; $display("FAIL bst_ack_pulse: got %b want 0", cpu_ack); end
    endtask

    task automatic test_be_zero();
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_be = 4'h0; cpu_addr = 32'h44; cpu_wdata = 32'hFFFF_FFFF;
        @(negedge clk);
        total++; if ({cpu_ack, rd_ce, wr_ce, cpu_stall} !== 4'b1000) begin bad++; $display("FAIL bez_ack: got %b want 1000", {cpu_ack, rd_ce, wr_ce, cpu_stall}); end
        cpu_req = 1'b0;
        @(negedge clk);
        total++; if ({cpu_ack, rd_ce, wr_ce} !== 3'b000) begin bad++; $display("FAIL bez_after: got %b want 000", {cpu_ack, rd_ce, wr_ce}); end
    endtask

`ifdef SRAM_BRIDGE_TIMEOUT_EN
    task automatic test_timeout();
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_be = 4'hF; cpu_addr = 32'h4;
        for (int i = 1; i <= 15; i++) begin
            @(negedge clk);
            total++; if ({rd_ce, cpu_ack, cpu_err} !== 3'b100) begin bad++; $display("FAIL tmo_wait_%0d: got %b want 100", i, {rd_ce, cpu_ack, cpu_err}); end
        end
        @(negedge clk);
        total++; if ({rd_ce, cpu_ack, cpu_err} !== 3'b011) begin bad++; $display("FAIL tmo_expire: got %b want 011", {rd_ce, cpu_ack, cpu_err}); end
        cpu_req = 1'b0;
        @(negedge clk);
        total++; if ({cpu_ack, cpu_err} !== 2'b00) begin bad++; $display("FAIL tmo_pulse: got %b want 00", {cpu_ack, cpu_err}); end
    endtask
`else
    task automatic test_timeout();
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_be = 4'hF; cpu_addr = 32'h4;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            total++; if ({rd_ce, cpu_ack, cpu_err} !== 3'b100) begin bad++; $display("FAIL long_wait_%0d: got %b want 100", i, {rd_ce, cpu_ack, cpu_err}); end
        end
        rd_fin = 1'b1; rd_data = 32'hCAFE_F00D;
        @(negedge clk);
        rd_fin = 1'b0; rd_data = 32'h0;
        total++; if ({cpu_ack, cpu_err, rd_ce} !== 3'b100) begin bad++; $display("FAIL long_ack: got %b want 100", {cpu_ack, cpu_err, rd_ce}); end
        total++; if (cpu_rdata !== 32'hCAFE_F00D) begin bad++; $display("FAIL long_rdata: got %h want cafef00d", cpu_rdata); end
        cpu_req = 1'b0;
        @(negedge clk);
    endtask
`endif

    task automatic test_rst_in_wr();
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_be = 4'hF; cpu_addr = 32'hC; cpu_wdata = 32'h55AA_55AA;
        @(negedge clk);
        total++; if (wr_ce !== 1'b1) begin bad++; $display("FAIL rst_pre_wr_ce: got %b want 1", wr_ce); end
        rst = 1'b1; cpu_req = 1'b0;
        @(negedge clk);
        total++; if ({wr_ce, rd_ce, cpu_ack, cpu_stall} !== 4'b0000) begin bad++; $display("FAIL rst_wr_drop: got %b want 0000", {wr_ce, rd_ce, cpu_ack, cpu_stall}); end
        total++; if (cpu_rdata !== 32'h0) begin bad++; $display("FAIL rst_rdata_clear: got %h want 0", cpu_rdata); end
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            total++; if ({wr_ce, cpu_ack, cpu_stall} !== 3'b000) begin bad++; $display("FAIL rst_idle_%0d: got %b want 000", i, {wr_ce, cpu_ack, cpu_stall}); end
        end
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h40;
        #1;
        total++; if (cpu_stall !== 1'b1) begin bad++; $display("FAIL rst_new_stall: got %b want 1", cpu_stall); end
        @(negedge clk);
        total++; if ({rd_ce, rd_addr} !== {1'b1, 20'h10}) begin bad++; $display("FAIL rst_new_rd: got %h want 100010", {rd_ce, rd_addr}); end
        rd_fin = 1'b1; rd_data = 32'h0102_0304;
        @(negedge clk);
        rd_fin = 1'b0; rd_data = 32'h0;
        total++; if ({cpu_ack, cpu_err} !== 2'b10) begin bad++; $display("FAIL rst_new_ack: got %b want 10", {cpu_ack, cpu_err}); end
        total++; if (cpu_rdata !== 32'h0102_0304) begin bad++; $display("FAIL rst_new_rdata: got %h want 01020304", cpu_rdata); end
        cpu_req = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_load();
        test_full_store();
        test_byte_store();
        test_be_zero();
        test_timeout();
        test_rst_in_wr();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL sim_time_limit: got timeout want completion");
        $fatal(1, "simulation time limit reached");
    end

endmodule
